// File: rtl/spi_reg_arbiter_pkg.sv
// Shared definitions for the SPI / local register-bus arbiter.
package spi_reg_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_SPI_WAIT_DATA = 2'd1,
    ST_BUS_SPI       = 2'd2,
    ST_BUS_LOC       = 2'd3
  } state_e;

  // Position of the write flag inside the SPI command byte
  localparam int CMD_WR_BIT = 7;

  // Read data returned to a requester whose bus access timed out
  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

  // Request / grant vector indices for the round-robin arbiter
  localparam int REQ_SPI = 0;
  localparam int REQ_LOC = 1;

endpackage

// File: rtl/spi_reg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant pointer.
// On contention the requester that was not granted last wins.
module rr_arb2 #(
  parameter logic FIRST_IDX = 1'b0  // index favoured on the first contention
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // One-hot grant and pointer update
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt != 2'b00) begin
      last_d = gnt[1];
    end
  end

  // Last-grant pointer; reset so that FIRST_IDX counts as "not granted last"
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ~FIRST_IDX;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Arbitrates a shared register bus between SPI commands and a local requester.
// SPI commands pass through a one-deep slot; a write command waits there for
// its data word before it becomes eligible for arbitration.
module spi_reg_arbiter
  import spi_reg_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT   = 8'd255,
  parameter int         SPI_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd_addr,
  input  logic        cmd_addr_valid,
  input  logic [15:0] cmd_data,
  input  logic        cmd_data_valid,
  output logic [15:0] spi_rdata,
  output logic        spi_rvalid,
  input  logic        loc_req,
  input  logic        loc_we,
  input  logic [6:0]  loc_addr,
  input  logic [15:0] loc_wdata,
  output logic [15:0] loc_rdata,
  output logic        loc_done,
  output logic        bus_req,
  output logic        bus_we,
  output logic [6:0]  bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        err_timeout
);

  state_e      state_q, state_d;

  logic        slot_vld_q, slot_vld_d;
  logic        slot_we_q, slot_we_d;
  logic        slot_rdy_q, slot_rdy_d;
  logic [6:0]  slot_addr_q, slot_addr_d;
  logic [15:0] slot_wdata_q, slot_wdata_d;

  logic [7:0]  wait_q, wait_d;
  logic [7:0]  wait_inc;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [6:0]  bus_addr_q, bus_addr_d;
  logic [15:0] bus_wdata_q, bus_wdata_d;
  logic [15:0] spi_rdata_q, spi_rdata_d;
  logic        spi_rvalid_q, spi_rvalid_d;
  logic [15:0] loc_rdata_q, loc_rdata_d;
  logic        loc_done_q, loc_done_d;
  logic        err_timeout_q, err_timeout_d;

  // Slot contents after this cycle's SPI strobes, before any grant consumes it
  logic        s_vld_n, s_we_n, s_rdy_n;
  logic [6:0]  s_addr_n;
  logic [15:0] s_wdata_n;

  logic [1:0]  arb_req;
  logic [1:0]  arb_gnt;
  logic        arb_en;
  logic        bus_done;
  logic [15:0] done_rdata;

  assign wait_inc = wait_q + 8'd1;

  // Capture SPI commands into the slot; a new command always replaces the old one
  always_comb begin
    s_vld_n   = slot_vld_q;
    s_we_n    = slot_we_q;
    s_rdy_n   = slot_rdy_q;
    s_addr_n  = slot_addr_q;
    s_wdata_n = slot_wdata_q;
    if (cmd_addr_valid) begin
      s_vld_n  = 1'b1;
      s_we_n   = cmd_addr[CMD_WR_BIT];
      s_rdy_n  = ~cmd_addr[CMD_WR_BIT];
      s_addr_n = cmd_addr[6:0];
    end else if (cmd_data_valid && slot_vld_q && slot_we_q && !slot_rdy_q) begin
      s_wdata_n = cmd_data;
      s_rdy_n   = 1'b1;
    end
  end

  // The cycle loc_done pulses the requester still holds loc_req, so mask it
  // there to avoid re-granting the access that just finished. An unready
  // SPI write holds off arbitration until its data word arrives.
  assign arb_req[REQ_SPI] = s_vld_n & s_rdy_n;
  assign arb_req[REQ_LOC] = loc_req & ~loc_done_q;
  assign arb_en           = (state_q == ST_IDLE) && !(s_vld_n && !s_rdy_n);

  rr_arb2 #(
    .FIRST_IDX((SPI_FIRST != 0) ? 1'b0 : 1'b1)
  ) u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (arb_req),
    .en  (arb_en),
    .gnt (arb_gnt)
  );

  // A bus access completes on ack, or on timeout with substitute read data
  assign bus_done   = bus_ack || (wait_inc == TIMEOUT);
  assign done_rdata = bus_ack ? bus_rdata : TIMEOUT_RDATA;

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    slot_vld_d    = s_vld_n;
    slot_we_d     = s_we_n;
    slot_rdy_d    = s_rdy_n;
    slot_addr_d   = s_addr_n;
    slot_wdata_d  = s_wdata_n;
    wait_d        = wait_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    spi_rdata_d   = spi_rdata_q;
    spi_rvalid_d  = 1'b0;
    loc_rdata_d   = loc_rdata_q;
    loc_done_d    = 1'b0;
    err_timeout_d = err_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (s_vld_n && !s_rdy_n) begin
          state_d = ST_SPI_WAIT_DATA;
        end else if (arb_gnt[REQ_SPI]) begin
          state_d     = ST_BUS_SPI;
          bus_req_d   = 1'b1;
          bus_we_d    = s_we_n;
          bus_addr_d  = s_addr_n;
          bus_wdata_d = s_wdata_n;
          wait_d      = 8'd0;
          slot_vld_d  = 1'b0;
          slot_rdy_d  = 1'b0;
        end else if (arb_gnt[REQ_LOC]) begin
          state_d     = ST_BUS_LOC;
          bus_req_d   = 1'b1;
          bus_we_d    = loc_we;
          bus_addr_d  = loc_addr;
          bus_wdata_d = loc_wdata;
          wait_d      = 8'd0;
        end
      end

      ST_SPI_WAIT_DATA: begin
        if (!s_vld_n || s_rdy_n) begin
          state_d = ST_IDLE;
        end
      end

      ST_BUS_SPI, ST_BUS_LOC: begin
        if (bus_done) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          wait_d    = 8'd0;
          if (!bus_ack) begin
            err_timeout_d = 1'b1;
          end
          if (state_q == ST_BUS_SPI) begin
            if (!bus_we_q) begin
              spi_rvalid_d = 1'b1;
              spi_rdata_d  = done_rdata;
            end
          end else begin
            loc_done_d = 1'b1;
            if (!bus_we_q) begin
              loc_rdata_d = done_rdata;
            end
          end
        end else begin
          wait_d = wait_inc;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, slot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      slot_vld_q    <= 1'b0;
      slot_we_q     <= 1'b0;
      slot_rdy_q    <= 1'b0;
      slot_addr_q   <= 7'd0;
      slot_wdata_q  <= 16'd0;
      wait_q        <= 8'd0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 7'd0;
      bus_wdata_q   <= 16'd0;
      spi_rdata_q   <= 16'd0;
      spi_rvalid_q  <= 1'b0;
      loc_rdata_q   <= 16'd0;
      loc_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_vld_q    <= slot_vld_d;
      slot_we_q     <= slot_we_d;
      slot_rdy_q    <= slot_rdy_d;
      slot_addr_q   <= slot_addr_d;
      slot_wdata_q  <= slot_wdata_d;
      wait_q        <= wait_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      spi_rdata_q   <= spi_rdata_d;
      spi_rvalid_q  <= spi_rvalid_d;
      loc_rdata_q   <= loc_rdata_d;
      loc_done_q    <= loc_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign spi_rdata   = spi_rdata_q;
  assign spi_rvalid  = spi_rvalid_q;
  assign loc_rdata   = loc_rdata_q;
  assign loc_done    = loc_done_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed testbench for spi_reg_arbiter (TIMEOUT=4, SPI_FIRST=1).
module tb_spi_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd_addr;
  logic        cmd_addr_valid;
  logic [15:0] cmd_data;
  logic        cmd_data_valid;
  logic [15:0] spi_rdata;
  logic        spi_rvalid;
  logic        loc_req;
  logic        loc_we;
  logic [6:0]  loc_addr;
  logic [15:0] loc_wdata;
  logic [15:0] loc_rdata;
  logic        loc_done;
  logic        bus_req;
  logic        bus_we;
  logic [6:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  spi_reg_arbiter #(
    .TIMEOUT   (8'd4),
    .SPI_FIRST (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_addr       (cmd_addr),
    .cmd_addr_valid (cmd_addr_valid),
    .cmd_data       (cmd_data),
    .cmd_data_valid (cmd_data_valid),
    .spi_rdata      (spi_rdata),
    .spi_rvalid     (spi_rvalid),
    .loc_req        (loc_req),
    .loc_we         (loc_we),
    .loc_addr       (loc_addr),
    .loc_wdata      (loc_wdata),
    .loc_rdata      (loc_rdata),
    .loc_done       (loc_done),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_loc;
    logic [7:0]  cmd;       // bit7 = write, [6:0] = address (also used for local)
    logic [15:0] wdata;
    logic [15:0] rdata;     // value driven on bus_rdata with the ack
    int          dly;       // cycles between grant and ack
    logic [6:0]  exp_addr;
    logic        exp_we;
    logic [15:0] exp_wdata;
    logic        exp_rvalid;
    logic        exp_done;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus();
    int i = 0;
    while (bus_req !== 1'b1 && i < 20) begin
      tick();
      i++;
    end
    check("bus_req_grant", {31'd0, bus_req}, 32'd1);
  endtask

  task automatic ack(input logic [15:0] d);
    bus_ack   = 1'b1;
    bus_rdata = d;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 16'd0;
  endtask

  task automatic spi_cmd(input logic [7:0] a);
    cmd_addr       = a;
    cmd_addr_valid = 1'b1;
    tick();
    cmd_addr_valid = 1'b0;
  endtask

  task automatic spi_data(input logic [15:0] d);
    cmd_data       = d;
    cmd_data_valid = 1'b1;
    tick();
    cmd_data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vecs[0] = '{0, 8'h05, 16'h0000, 16'h1234, 2, 7'h05, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234};
    vecs[1] = '{0, 8'h8A, 16'hBEEF, 16'h5555, 1, 7'h0A, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1, 8'h33, 16'h0000, 16'hA5A5, 0, 7'h33, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5};
    vecs[3] = '{1, 8'hFF, 16'h0F0F, 16'h3333, 2, 7'h7F, 1'b1, 16'h0F0F, 1'b0, 1'b1, 16'h0000};
    vecs[4] = '{0, 8'h7F, 16'h0000, 16'hFFFF, 3, 7'h7F, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hFFFF};
    vecs[5] = '{0, 8'hFF, 16'h0001, 16'h0000, 0, 7'h7F, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000};

    rst = 1'b1; cmd_addr = 8'd0; cmd_addr_valid = 1'b0; cmd_data = 16'd0; cmd_data_valid = 1'b0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = 7'd0; loc_wdata = 16'd0; bus_ack = 1'b0; bus_rdata = 16'd0;
    tick();
    tick();
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_outputs", {spi_rvalid, loc_done, err_timeout, bus_we, bus_addr, spi_rdata}, 32'd0);
    check("rst_data", {loc_rdata, bus_wdata}, 32'd0);
    rst = 1'b0;
    tick();

    // Contention from reset: SPI first, then alternating
    cmd_addr = 8'h05; cmd_addr_valid = 1'b1;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 7'h22;
    tick();
    cmd_addr_valid = 1'b0;
    check("con1_req", {31'd0, bus_req}, 32'd1);
    check("con1_addr", {25'd0, bus_addr}, {25'd0, 7'h05});
    spi_cmd(8'h06);
    ack(16'h0101);
    check("con1_rvalid", {31'd0, spi_rvalid}, 32'd1);
    check("con1_rdata", {16'd0, spi_rdata}, 32'h0101);
    tick();
    check("con2_addr", {25'd0, bus_addr}, {25'd0, 7'h22});
    ack(16'h0202);
    loc_req = 1'b0;
    check("con2_done", {31'd0, loc_done}, 32'd1);
    check("con2_rdata", {16'd0, loc_rdata}, 32'h0202);
    tick();
    check("con3_addr", {25'd0, bus_addr}, {25'd0, 7'h06});
    ack(16'h0303);
    check("con3_rdata", {15'd0, spi_rvalid, spi_rdata}, 32'h1_0303);
    cmd_addr = 8'h07; cmd_addr_valid = 1'b1;
    loc_req = 1'b1; loc_addr = 7'h23;
    tick();
    cmd_addr_valid = 1'b0;
    check("con4_addr_loc", {25'd0, bus_addr}, {25'd0, 7'h23});
    ack(16'h0404);
    loc_req = 1'b0;
    check("con4_done", {31'd0, loc_done}, 32'd1);
    tick();
    check("con5_addr_spi", {25'd0, bus_addr}, {25'd0, 7'h07});
    ack(16'h0505);
    check("con5_rvalid", {31'd0, spi_rvalid}, 32'd1);
    tick();

    // Table of single accesses
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].is_loc) begin
        loc_req = 1'b1; loc_we = vecs[v].cmd[7]; loc_addr = vecs[v].cmd[6:0]; loc_wdata = vecs[v].wdata;
        tick();
      end else begin
        spi_cmd(vecs[v].cmd);
        if (vecs[v].cmd[7]) spi_data(vecs[v].wdata);
      end
      wait_bus();
      check($sformatf("v%0d_we", v), {31'd0, bus_we}, {31'd0, vecs[v].exp_we});
      check($sformatf("v%0d_addr", v), {25'd0, bus_addr}, {25'd0, vecs[v].exp_addr});
      if (vecs[v].exp_we) check($sformatf("v%0d_wdata", v), {16'd0, bus_wdata}, {16'd0, vecs[v].exp_wdata});
      for (int k = 0; k < vecs[v].dly; k++) begin
        tick();
        check($sformatf("v%0d_hold", v), {24'd0, bus_req, bus_addr}, {24'd0, 1'b1, vecs[v].exp_addr});
      end
      ack(vecs[v].rdata);
      if (vecs[v].is_loc) loc_req = 1'b0;
      check($sformatf("v%0d_req_drop", v), {31'd0, bus_req}, 32'd0);
      check($sformatf("v%0d_rvalid", v), {31'd0, spi_rvalid}, {31'd0, vecs[v].exp_rvalid});
      check($sformatf("v%0d_done", v), {31'd0, loc_done}, {31'd0, vecs[v].exp_done});
      if (vecs[v].exp_rvalid) check($sformatf("v%0d_spi_rdata", v), {16'd0, spi_rdata}, {16'd0, vecs[v].exp_rdata});
      if (vecs[v].exp_done && !vecs[v].exp_we)
        check($sformatf("v%0d_loc_rdata", v), {16'd0, loc_rdata}, {16'd0, vecs[v].exp_rdata});
      tick();
      check($sformatf("v%0d_pulse_end", v), {30'd0, spi_rvalid, loc_done}, 32'd0);
    end
    check("no_err_after_table", {31'd0, err_timeout}, 32'd0);

    // Stray ack while idle
    bus_ack = 1'b1; bus_rdata = 16'h7777;
    tick();
    bus_ack = 1'b0; bus_rdata = 16'd0;
    check("idle_ack_ignored", {29'd0, bus_req, spi_rvalid, loc_done}, 32'd0);

    // Write restarted by a second command before its data
    spi_cmd(8'h8A);
    spi_cmd(8'h8B);
    spi_data(16'h1111);
    wait_bus();
    check("restart_addr", {24'd0, bus_we, bus_addr}, {24'd0, 1'b1, 7'h0B});
    check("restart_wdata", {16'd0, bus_wdata}, 32'h1111);
    ack(16'h0000);
    check("restart_no_rvalid", {31'd0, spi_rvalid}, 32'd0);
    tick();

    // Two commands during a local access: only the second executes
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 7'h50;
    tick();
    check("slot_loc_addr", {25'd0, bus_addr}, {25'd0, 7'h50});
    spi_cmd(8'h10);
    spi_cmd(8'h12);
    ack(16'h4444);
    loc_req = 1'b0;
    check("slot_loc_done", {15'd0, loc_done, loc_rdata}, 32'h1_4444);
    tick();
    check("slot_spi_addr", {24'd0, bus_we, bus_addr}, {24'd0, 1'b0, 7'h12});
    ack(16'h9999);
    check("slot_spi_rdata", {15'd0, spi_rvalid, spi_rdata}, 32'h1_9999);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus_req === 1'b1) cnt++;
    end
    check("slot_no_extra", cnt, 0);

    // SPI read timeout
    spi_cmd(8'h11);
    cnt = 0;
    while (bus_req === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("to_spi_cycles", cnt, 4);
    check("to_spi_rvalid", {15'd0, spi_rvalid, spi_rdata}, 32'h1_DEAD);
    check("to_err_set", {31'd0, err_timeout}, 32'd1);
    tick();
    check("to_err_sticky", {30'd0, err_timeout, spi_rvalid}, 32'h2);

    // Local read timeout
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 7'h60;
    tick();
    cnt = 0;
    while (bus_req === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    loc_req = 1'b0;
    check("to_loc_cycles", cnt, 4);
    check("to_loc_done", {15'd0, loc_done, loc_rdata}, 32'h1_DEAD);
    tick();

    // Reset in the middle of a local access
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 7'h44;
    tick();
    check("rmid_granted", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    loc_req = 1'b0;
    check("rmid_req_drop", {30'd0, bus_req, loc_done}, 32'd0);
    check("rmid_err_clear", {31'd0, err_timeout}, 32'd0);
    tick();
    check("rmid_idle", {30'd0, bus_req, loc_done}, 32'd0);

    // Pointer is back to SPI-first after reset
    cmd_addr = 8'h09; cmd_addr_valid = 1'b1;
    loc_req = 1'b1; loc_addr = 7'h2A;
    tick();
    cmd_addr_valid = 1'b0;
    check("rr_after_rst", {25'd0, bus_addr}, {25'd0, 7'h09});
    ack(16'h0909);
    tick();
    check("rr_after_rst_loc", {25'd0, bus_addr}, {25'd0, 7'h2A});
    ack(16'h2A2A);
    loc_req = 1'b0;
    check("rr_after_rst_done", {31'd0, loc_done}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
